// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_add_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default operand width
    localparam int SERIAL_ADD_WIDTH = 4;

    // Bit counter width for a given operand width (never below 1 bit)
    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle of the bit-serial adder.
// The Ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 4
) ();
    logic             Start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] S;
    logic             Co;
`ifdef SERIAL_ADD_OVF_EN
    logic             Ovf;

    modport master (output Start, A, B, Cin, input Busy, Done, S, Co, Ovf);
    modport slave  (input Start, A, B, Cin, output Busy, Done, S, Co, Ovf);
`else
    modport master (output Start, A, B, Cin, input Busy, Done, S, Co);
    modport slave  (input Start, A, B, Cin, output Busy, Done, S, Co);
`endif
endinterface

// File: rtl/serial_add_ctrl_fa.sv
// Combinational full-adder bit slice shared across all bit positions.
module FA (
    input  logic A,
    input  logic B,
    input  logic Ci,
    output logic S,
    output logic Co
);
    assign S  = A ^ B ^ Ci;
    assign Co = (A & B) | (Ci & (A ^ B));
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one FA slice, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    serial_add_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] psum_q;
    logic [WIDTH-1:0] psum_d;
    logic [CNT_W-1:0] cnt_q;
    logic             cy_q;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q;
`endif

    FA u_fa (
        .A  (a_q[0]),
        .B  (b_q[0]),
        .Ci (cy_q),
        .S  (fa_s),
        .Co (fa_co)
    );

    // New sum bit enters at the MSB so the first (LSB) bit lands at bit 0 after WIDTH shifts
    assign psum_d   = {fa_s, psum_q[WIDTH-1:1]};
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Sequencer: capture on Start, shift one bit per cycle, publish result on the last bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.Start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        cy_q    <= bus.Cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q    <= a_q >> 1;
                    b_q    <= b_q >> 1;
                    cy_q   <= fa_co;
                    psum_q <= psum_d;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        s_q     <= psum_d;
                        co_q    <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        // cy_q holds the carry into the MSB slice during the last bit
                        ovf_q   <= cy_q ^ fa_co;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.S    = s_q;
    assign bus.Co   = co_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.Ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed testbench for serial_add_ctrl (WIDTH = 4).
module tb_serial_add_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [W-1:0] hold_s;
    logic         hold_co;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.Start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.Cin = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        n_cmp++;
        if (bus.Done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", bus.Done); end
        n_cmp++;
        if (bus.S !== 4'd0) begin n_err++; $display("FAIL reset_s got %0d want 0", bus.S); end
        n_cmp++;
        if (bus.Co !== 1'b0) begin n_err++; $display("FAIL reset_co got %b want 0", bus.Co); end
`ifdef SERIAL_ADD_OVF_EN
        n_cmp++;
        if (bus.Ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", bus.Ovf); end
`endif
        hold_s  = 4'd0;
        hold_co = 1'b0;
    endtask

    // One full operation with cycle-exact Busy/Done checks
    task automatic test_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                            input logic [W-1:0] es, input logic eco, input logic eovf,
                            input string name);
        bus.A = a;
        bus.B = b;
        bus.Cin = cin;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        bus.A = ~a;
        bus.B = ~b;
        bus.Cin = ~cin;
        for (int i = 0; i < W; i++) begin
            n_cmp++;
            if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) begin
                n_err++;
                $display("FAIL %s_run%0d busy/done got %b%b want 10", name, i, bus.Busy, bus.Done);
            end
            n_cmp++;
            if (bus.S !== hold_s || bus.Co !== hold_co) begin
                n_err++;
                $display("FAIL %s_hold%0d s/co got %0d/%b want %0d/%b", name, i, bus.S, bus.Co, hold_s, hold_co);
            end
            tick();
        end
        n_cmp++;
        if (bus.Done !== 1'b1 || bus.Busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s_done busy/done got %b%b want 01", name, bus.Busy, bus.Done);
        end
        n_cmp++;
        if (bus.S !== es || bus.Co !== eco) begin
            n_err++;
            $display("FAIL %s_result s/co got %0d/%b want %0d/%b", name, bus.S, bus.Co, es, eco);
        end
`ifdef SERIAL_ADD_OVF_EN
        n_cmp++;
        if (bus.Ovf !== eovf) begin n_err++; $display("FAIL %s_ovf got %b want %b", name, bus.Ovf, eovf); end
`else
        if (eovf === 1'bx) $display("note: unexpected x");
`endif
        hold_s  = es;
        hold_co = eco;
        tick();
        n_cmp++;
        if (bus.Done !== 1'b0 || bus.Busy !== 1'b0 || bus.S !== es) begin
            n_err++;
            $display("FAIL %s_after busy/done/s got %b%b/%0d want 00/%0d", name, bus.Busy, bus.Done, bus.S, es);
        end
    endtask

    // Start re-pulsed mid-operation must be ignored
    task automatic test_start_in_run();
        int ndone = 0;
        logic [W-1:0] s_at_done = '0;
        logic         co_at_done = 1'b0;
        bus.A = 4'd6;
        bus.B = 4'd4;
        bus.Cin = 1'b0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        bus.A = 4'd1;
        bus.B = 4'd1;
        bus.Start = 1'b1;
        tick();
        tick();
        bus.Start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.Done === 1'b1) begin
                ndone++;
                s_at_done = bus.S;
                co_at_done = bus.Co;
            end
        end
        n_cmp++;
        if (ndone != 1) begin n_err++; $display("FAIL rerun_done_count got %0d want 1", ndone); end
        n_cmp++;
        if (s_at_done !== 4'd10 || co_at_done !== 1'b0) begin
            n_err++;
            $display("FAIL rerun_result s/co got %0d/%b want 10/0", s_at_done, co_at_done);
        end
        hold_s  = 4'd10;
        hold_co = 1'b0;
    endtask

    // Start held high: Done every W+2 cycles, result held between strobes
    task automatic test_back_to_back();
        logic exp_done;
        bus.A = 4'd2;
        bus.B = 4'd3;
        bus.Cin = 1'b0;
        bus.Start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_done = (i == 4 || i == 10 || i == 16);
            n_cmp++;
            if (bus.Done !== exp_done) begin
                n_err++;
                $display("FAIL b2b_done%0d got %b want %b", i, bus.Done, exp_done);
            end
            if (i >= 4) begin
                n_cmp++;
                if (bus.S !== 4'd5 || bus.Co !== 1'b0) begin
                    n_err++;
                    $display("FAIL b2b_s%0d s/co got %0d/%b want 5/0", i, bus.S, bus.Co);
                end
            end
        end
        bus.Start = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        hold_s  = 4'd5;
        hold_co = 1'b0;
    endtask

    // Reset in the second RUN cycle aborts with no Done
    task automatic test_reset_abort();
        int ndone = 0;
        bus.A = 4'd15;
        bus.B = 4'd1;
        bus.Cin = 1'b0;
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (bus.S !== 4'd0 || bus.Co !== 1'b0 || bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
            n_err++;
            $display("FAIL abort_state s/co/busy/done got %0d/%b/%b/%b want 0/0/0/0", bus.S, bus.Co, bus.Busy, bus.Done);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.Done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin n_err++; $display("FAIL abort_done_count got %0d want 0", ndone); end
        hold_s  = 4'd0;
        hold_co = 1'b0;
        test_add(4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0, "after_abort");
    endtask

    initial begin
        test_reset();
        test_add(4'd0,  4'd0,  1'b0, 4'd0,  1'b0, 1'b0, "zero");
        test_add(4'd7,  4'd9,  1'b0, 4'd0,  1'b1, 1'b0, "a7b9");
        test_add(4'd5,  4'd3,  1'b1, 4'd9,  1'b0, 1'b1, "a5b3c1");
        test_add(4'd15, 4'd15, 1'b1, 4'd15, 1'b1, 1'b0, "max");
        test_start_in_run();
        test_back_to_back();
        test_reset_abort();
        test_add(4'd7,  4'd1,  1'b0, 4'd8,  1'b0, 1'b1, "ovf_pos");
        test_add(4'd8,  4'd8,  1'b0, 4'd0,  1'b1, 1'b1, "ovf_neg");
        test_add(4'd3,  4'd2,  1'b0, 4'd5,  1'b0, 1'b0, "no_ovf");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
